gs_dac_pwm: RTL and testbench
=============================

# gs_dac_pwm

Parametrised multi-channel General Sound DAC engine for the Sizif-512 extension CPLD. It holds one offset-binary sample and one volume per channel and turns each into a single-bit first-order delta-sigma stream, gated by a volume PWM. The stream drives one external RC filter pin per channel. It sits between the GS bus snoop logic, which decodes DAC memory reads and volume port writes, and the gdacN pins. It generalises the fixed 4×8-bit/6-bit-volume GS DAC to any channel count and width, and adds registered outputs, a global enable and optional glitch-free period-aligned updates.

## Interface
Parameters:
- CHANNELS, 4, number of DAC channels (1..8)
- DW, 8, sample width in bits, offset-binary, MSB = sign (≥3)
- VW, 6, volume width in bits
- VOL_STEP, 31, volume counter increment; must be odd, so the period is 2^VW

Ports:
- clk32  in  1  system clock, 32 MHz
- rst  in  1  asynchronous reset, active-high
- en  in  1  global enable; low = all channels idle at midpoint
- smp_we  in  1  sample write strobe, one cycle
- smp_ch  in  max(1,clog2(CHANNELS))  sample target channel
- smp_d  in  DW  raw offset-binary sample
- vol_we  in  1  volume write strobe, one cycle
- vol_ch  in  max(1,clog2(CHANNELS))  volume target channel
- vol_d  in  VW  volume; 0 = silent, all-ones = full
- dac  out  CHANNELS  per-channel delta-sigma bit, registered

## Operation
- Sample conversion on write:
  - sign = smp_d[DW-1].
  - mag = sign ? smp_d[DW-2:0] : ~smp_d[DW-2:0].
  - Both fields are stored per channel.
- Writes with ch ≥ CHANNELS are ignored. Sample and volume ports are independent. Writes to the same channel in the same cycle both apply.
- vol_cnt (VW bits) adds VOL_STEP every cycle and wraps modulo 2^VW.
- vol_en[i] is registered each cycle as (vol_cnt < vol[i]) || (vol[i] == all-ones).
- Accumulator acc[i] is DW bits; bit DW-1 is the carry.
  - If en && vol_en[i]: acc[i] ← {1'b0, acc[i][DW-2:0]} + mag[i].
  - Otherwise: acc[i][DW-1] ← 0 and the low bits hold.
  - When en = 0, the low bits also clear to 0.
- mid is a toggle flip-flop that inverts every cycle. It is the midpoint reference.
- Output: dac[i] ← acc[i][DW-1] ? sign[i] : mid.
- Reset values: samples (sign 0, mag 0), volumes 0, vol_cnt 0, vol_en 0, acc 0, mid 0, dac all 0.

## Timing
- Sample write captured at edge N. acc uses it at N+1. dac reflects it at N+2.
- Volume write at edge N. vol_en is updated at N+1. acc is affected at N+2. dac is affected at N+3.
- Volume PWM period is 2^VW cycles. vol_cnt == 0 exactly once per period.
- Reset asserted mid-stream: all state returns to reset values asynchronously. Counting resumes on the first edge after release.
- en falling: the next edge clears acc, so dac follows mid from N+2.
- en rising: accumulation restarts from acc = 0.

## Configuration
- GS_DAC_SYNC_UPDATE_EN defined:
  - Writes land in per-channel shadow registers.
  - All shadows copy into the active sample/volume registers on the edge where vol_cnt == 0.
  - Latency is up to 2^VW cycles plus the pipeline above.
  - A write coinciding with the copy edge lands in the shadow and is copied at the next boundary.
- Macro undefined: no shadow registers. Writes take effect with the latencies in Timing.

## Test plan
- Reset: hold rst 3 cycles with en=1 → dac=0 throughout. After release with vol=0 on all channels, dac[i] toggles 0,1,0,1 (mid).
- Full scale: ch0 vol_d=63, smp_d=0xFF (sign 1, mag 127) → over any 128-cycle window after settling, dac[0] is high in ≥127 cycles. smp_d=0x00 → dac[0] is high in ≤1 cycle.
- Zero magnitude: ch1 smp_d=0x80, vol 63 → acc never carries. dac[1] is high in exactly 64 of 128 cycles.
- Volume gating: ch2 vol_d=32, smp_d=0xFF → vol_en[2] is high in exactly 32 of every 64 cycles. dac[2] is high in 95±2 of 128 cycles. vol_d=0 → exactly 64 of 128.
- Out of range: with CHANNELS=3, write smp_ch=3 / vol_ch=3 → no channel state changes and dac[2:0] are unchanged versus the reference run.
- Update alignment: write ch0 smp_d=0xFF at vol_cnt=29. Without the macro, dac[0] changes behaviour at N+2. With GS_DAC_SYNC_UPDATE_EN, there is no change until the edge where vol_cnt == 0, then from 2 cycles later.

Source files
------------

// File: rtl/gs_dac_pwm.sv
`default_nettype none
// ============================================================================
// Module  : gs_dac_pwm
// Brief   : Multi-channel first-order delta-sigma DAC with volume PWM gating.
//           Define GS_DAC_SYNC_UPDATE_EN for shadowed, period-aligned updates.
// Revision: 1.0
// ============================================================================
module gs_dac_pwm #(
  parameter int CHANNELS = 4,
  parameter int DW       = 8,
  parameter int VW       = 6,
  parameter int VOL_STEP = 31,
  localparam int CW      = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                clk32,
  input  logic                rst,
  input  logic                en,
  input  logic                smp_we,
  input  logic [CW-1:0]       smp_ch,
  input  logic [DW-1:0]       smp_d,
  input  logic                vol_we,
  input  logic [CW-1:0]       vol_ch,
  input  logic [VW-1:0]       vol_d,
  output logic [CHANNELS-1:0] dac
);

  localparam logic [VW-1:0] VOL_INC  = VW'(VOL_STEP);
  localparam logic [VW-1:0] VOL_FULL = '1;

  logic [VW-1:0]       vol_cnt_q, vol_cnt_d;
  logic                mid_q;
  logic [CHANNELS-1:0] dac_q, dac_d;

  assign vol_cnt_d = vol_cnt_q + VOL_INC;
  assign dac       = dac_q;

`ifdef GS_DAC_SYNC_UPDATE_EN
  logic upd_boundary;
  assign upd_boundary = (vol_cnt_q == '0);
`endif

  always_ff @(posedge clk32 or posedge rst) begin
    if (rst) begin
      vol_cnt_q <= '0;
      mid_q     <= 1'b0;
      dac_q     <= '0;
    end else begin
      vol_cnt_q <= vol_cnt_d;
      mid_q     <= ~mid_q;
      dac_q     <= dac_d;
    end
  end

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    logic          smp_hit, vol_hit;
    logic [DW-2:0] new_mag;
    logic          sign_q;
    logic [DW-2:0] mag_q;
    logic [VW-1:0] vol_q;
    logic          vol_en_q, vol_en_d;
    logic [DW-1:0] acc_q, acc_d;

    assign smp_hit = smp_we && (smp_ch == CW'(i));
    assign vol_hit = vol_we && (vol_ch == CW'(i));
    // Offset-binary to sign/magnitude: negative codes are one's-complemented.
    assign new_mag = smp_d[DW-1] ? smp_d[DW-2:0] : ~smp_d[DW-2:0];

`ifdef GS_DAC_SYNC_UPDATE_EN
    logic          sh_sign_q;
    logic [DW-2:0] sh_mag_q;
    logic [VW-1:0] sh_vol_q;

    always_ff @(posedge clk32 or posedge rst) begin
      if (rst) begin
        sh_sign_q <= 1'b0;
        sh_mag_q  <= '0;
        sh_vol_q  <= '0;
        sign_q    <= 1'b0;
        mag_q     <= '0;
        vol_q     <= '0;
      end else begin
        if (smp_hit) begin
          sh_sign_q <= smp_d[DW-1];
          sh_mag_q  <= new_mag;
        end
        if (vol_hit) sh_vol_q <= vol_d;
        if (upd_boundary) begin
          sign_q <= sh_sign_q;
          mag_q  <= sh_mag_q;
          vol_q  <= sh_vol_q;
        end
      end
    end
`else
    always_ff @(posedge clk32 or posedge rst) begin
      if (rst) begin
        sign_q <= 1'b0;
        mag_q  <= '0;
        vol_q  <= '0;
      end else begin
        if (smp_hit) begin
          sign_q <= smp_d[DW-1];
          mag_q  <= new_mag;
        end
        if (vol_hit) vol_q <= vol_d;
      end
    end
`endif

    assign vol_en_d = (vol_cnt_q < vol_q) || (vol_q == VOL_FULL);

    // The carry lives for one cycle only; low bits are the phase residue.
    always_comb begin
      acc_d = {1'b0, acc_q[DW-2:0]};
      if (!en) begin
        acc_d = '0;
      end else if (vol_en_q) begin
        acc_d = {1'b0, acc_q[DW-2:0]} + {1'b0, mag_q};
      end
    end

    always_ff @(posedge clk32 or posedge rst) begin
      if (rst) begin
        vol_en_q <= 1'b0;
        acc_q    <= '0;
      end else begin
        vol_en_q <= vol_en_d;
        acc_q    <= acc_d;
      end
    end

    assign dac_d[i] = acc_q[DW-1] ? sign_q : mid_q;
  end

endmodule
`default_nettype wire

// File: tb/tb_gs_dac_pwm.sv
`default_nettype none
// tb_gs_dac_pwm : randomized self-checking bench for gs_dac_pwm, compared
// every cycle against an arithmetic reference model of the conversion rules.
module tb_gs_dac_pwm;

  localparam int CH = 3;
  localparam int DW = 8;
  localparam int VW = 6;
  localparam int VS = 31;
  localparam int P  = 64;
  localparam int H  = 128;
  localparam int CW = 2;

  logic          clk32 = 1'b0;
  logic          rst;
  logic          en;
  logic          smp_we;
  logic [CW-1:0] smp_ch;
  logic [DW-1:0] smp_d;
  logic          vol_we;
  logic [CW-1:0] vol_ch;
  logic [VW-1:0] vol_d;
  logic [CH-1:0] dac;

  int checks = 0;
  int errors = 0;

  // Reference model state (plain integers)
  int m_k;
  int m_sign[CH], m_mag[CH], m_vol[CH];
  int sh_sign[CH], sh_mag[CH], sh_vol[CH];
  int m_gate[CH], m_acc[CH], m_carry[CH];

  always #5 clk32 = ~clk32;

  gs_dac_pwm #(.CHANNELS(CH), .DW(DW), .VW(VW), .VOL_STEP(VS)) dut (
    .clk32 (clk32),
    .rst   (rst),
    .en    (en),
    .smp_we(smp_we),
    .smp_ch(smp_ch),
    .smp_d (smp_d),
    .vol_we(vol_we),
    .vol_ch(vol_ch),
    .vol_d (vol_d),
    .dac   (dac)
  );

  function automatic int dec_sign(input logic [DW-1:0] d);
    return d[DW-1] ? 1 : 0;
  endfunction

  function automatic int dec_mag(input logic [DW-1:0] d);
    int low;
    low = int'(d) % H;
    return d[DW-1] ? low : (H - 1 - low);
  endfunction

  task automatic model_reset();
    m_k = 0;
    for (int c = 0; c < CH; c++) begin
      m_sign[c] = 0; m_mag[c] = 0; m_vol[c] = 0;
      sh_sign[c] = 0; sh_mag[c] = 0; sh_vol[c] = 0;
      m_gate[c] = 0; m_acc[c] = 0; m_carry[c] = 0;
    end
  endtask

  // One clock: predict from pre-edge state and inputs, then compare after edge.
  task automatic tick();
    int cnt, s;
    int nd[CH], ng[CH], na[CH], nc[CH];
    logic [CH-1:0] exp_v;
    cnt = (m_k * VS) % P;
    for (int c = 0; c < CH; c++) begin
      nd[c] = (m_carry[c] != 0) ? m_sign[c] : (m_k % 2);
      if (en && m_gate[c] != 0) begin
        s = m_acc[c] + m_mag[c];
        nc[c] = (s >= H) ? 1 : 0;
        na[c] = s % H;
      end else begin
        nc[c] = 0;
        na[c] = en ? m_acc[c] : 0;
      end
      ng[c] = (cnt < m_vol[c] || m_vol[c] == P - 1) ? 1 : 0;
    end
`ifdef GS_DAC_SYNC_UPDATE_EN
    if (cnt == 0) begin
      for (int c = 0; c < CH; c++) begin
        m_sign[c] = sh_sign[c]; m_mag[c] = sh_mag[c]; m_vol[c] = sh_vol[c];
      end
    end
    if (smp_we && int'(smp_ch) < CH) begin
      sh_sign[smp_ch] = dec_sign(smp_d);
      sh_mag[smp_ch]  = dec_mag(smp_d);
    end
    if (vol_we && int'(vol_ch) < CH) sh_vol[vol_ch] = int'(vol_d);
`else
    if (smp_we && int'(smp_ch) < CH) begin
      m_sign[smp_ch] = dec_sign(smp_d);
      m_mag[smp_ch]  = dec_mag(smp_d);
    end
    if (vol_we && int'(vol_ch) < CH) m_vol[vol_ch] = int'(vol_d);
`endif
    @(posedge clk32);
    #1;
    for (int c = 0; c < CH; c++) begin
      m_gate[c] = ng[c]; m_acc[c] = na[c]; m_carry[c] = nc[c];
      exp_v[c] = (nd[c] != 0);
    end
    m_k = (m_k + 1) % P;
    checks++;
    if (dac !== exp_v) begin
      errors++;
      $display("FAIL dac_stream t=%0t got=%b exp=%b", $time, dac, exp_v);
    end
    smp_we = 1'b0;
    vol_we = 1'b0;
  endtask

  task automatic write_smp(input int ch, input logic [DW-1:0] d);
    smp_we = 1'b1; smp_ch = CW'(ch); smp_d = d;
    tick();
  endtask

  task automatic write_vol(input int ch, input logic [VW-1:0] v);
    vol_we = 1'b1; vol_ch = CW'(ch); vol_d = v;
    tick();
  endtask

  task automatic count_high(input int ch, input int n, output int cnt);
    cnt = 0;
    for (int t = 0; t < n; t++) begin
      tick();
      if (dac[ch]) cnt++;
    end
  endtask

  task automatic test_reset();
    logic [CH-1:0] exp_v;
    rst = 1'b1; en = 1'b1;
    for (int t = 0; t < 3; t++) begin
      @(posedge clk32); #1;
      checks++;
      if (dac !== '0) begin
        errors++;
        $display("FAIL reset_hold got=%b exp=%b", dac, {CH{1'b0}});
      end
    end
    rst = 1'b0;
    model_reset();
    for (int t = 0; t < 6; t++) begin
      tick();
      exp_v = (t % 2 == 1) ? '1 : '0;
      checks++;
      if (dac !== exp_v) begin
        errors++;
        $display("FAIL reset_mid t=%0d got=%b exp=%b", t, dac, exp_v);
      end
    end
  endtask

  task automatic test_full_scale();
    int n;
    write_vol(0, 6'd63);
    write_smp(0, 8'hFF);
    repeat (80) tick();
    count_high(0, 128, n);
    checks++;
    if (n < 127) begin
      errors++;
      $display("FAIL full_pos high=%0d need>=127", n);
    end
    write_smp(0, 8'h00);
    repeat (80) tick();
    count_high(0, 128, n);
    checks++;
    if (n > 1) begin
      errors++;
      $display("FAIL full_neg high=%0d need<=1", n);
    end
  endtask

  task automatic test_zero_mag();
    int n;
    write_vol(1, 6'd63);
    write_smp(1, 8'h80);
    repeat (80) tick();
    count_high(1, 128, n);
    checks++;
    if (n != 64) begin
      errors++;
      $display("FAIL zero_mag high=%0d need=64", n);
    end
  endtask

  task automatic test_vol_gating();
    int n;
    write_vol(2, 6'd32);
    write_smp(2, 8'hFF);
    repeat (80) tick();
    count_high(2, 128, n);
    checks++;
    if (n < 93 || n > 97) begin
      errors++;
      $display("FAIL vol_half high=%0d need=93..97", n);
    end
    write_vol(2, 6'd0);
    repeat (80) tick();
    count_high(2, 128, n);
    checks++;
    if (n != 64) begin
      errors++;
      $display("FAIL vol_zero high=%0d need=64", n);
    end
  endtask

  task automatic test_out_of_range();
    int n1, n2;
    smp_we = 1'b1; smp_ch = 2'd3; smp_d = 8'hFF;
    vol_we = 1'b1; vol_ch = 2'd3; vol_d = 6'd63;
    tick();
    repeat (80) tick();
    n1 = 0; n2 = 0;
    for (int t = 0; t < 128; t++) begin
      tick();
      if (dac[1]) n1++;
      if (dac[2]) n2++;
    end
    checks++;
    if (n1 != 64 || n2 != 64) begin
      errors++;
      $display("FAIL out_of_range ch1=%0d ch2=%0d need=64,64", n1, n2);
    end
  endtask

  task automatic test_en_toggle();
    logic prev;
    en = 1'b0;
    tick();
    tick();
    prev = dac[0];
    for (int t = 0; t < 8; t++) begin
      tick();
      checks++;
      if (dac[0] === prev || dac !== {CH{dac[0]}}) begin
        errors++;
        $display("FAIL en_low_mid got=%b prev0=%b", dac, prev);
      end
      prev = dac[0];
    end
    en = 1'b1;
    repeat (20) tick();
  endtask

  task automatic test_alignment();
    int n, guard;
    write_smp(0, 8'h80);
    repeat (80) tick();
    guard = 0;
    while ((m_k * VS) % P != 29 && guard < P) begin
      tick();
      guard++;
    end
    write_smp(0, 8'hFF);
    repeat (80) tick();
    count_high(0, 64, n);
    checks++;
    if (n < 63) begin
      errors++;
      $display("FAIL align_after high=%0d need>=63", n);
    end
  endtask

  task automatic test_random();
    for (int t = 0; t < 1500; t++) begin
      if ($urandom_range(0, 3) == 0) begin
        smp_we = 1'b1;
        smp_ch = CW'($urandom_range(0, 3));
        smp_d  = DW'($urandom);
      end
      if ($urandom_range(0, 5) == 0) begin
        vol_we = 1'b1;
        vol_ch = CW'($urandom_range(0, 3));
        vol_d  = VW'($urandom);
      end
      if ($urandom_range(0, 63) == 0) en = ~en;
      tick();
    end
    en = 1'b1;
  endtask

  task automatic test_async_reset();
    int guard;
    guard = 0;
    while (dac === '0 && guard < 8) begin
      tick();
      guard++;
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if (dac !== '0) begin
      errors++;
      $display("FAIL async_reset got=%b exp=%b", dac, {CH{1'b0}});
    end
    @(posedge clk32); #1;
    rst = 1'b0;
    model_reset();
    repeat (10) tick();
  endtask

  initial begin
    rst = 1'b1; en = 1'b1;
    smp_we = 1'b0; smp_ch = '0; smp_d = '0;
    vol_we = 1'b0; vol_ch = '0; vol_d = '0;
    model_reset();
    test_reset();
    test_full_scale();
    test_zero_mag();
    test_vol_gating();
    test_out_of_range();
    test_en_toggle();
    test_alignment();
    test_random();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
